// File: rtl/avm_hram_tester_pkg.sv
// Shared types and constants for the Avalon-MM HyperRAM burst tester.
package avm_hram_tester_pkg;

    localparam int DATA_W  = 16;
    localparam int BURST_W = 11;
    localparam int ADDR_W  = 32;

    localparam logic [DATA_W-1:0] LFSR_MASK         = 16'hB400;
    localparam logic [DATA_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE
    } tester_state_t;

    // Galois step for x^16+x^14+x^13+x^11+1, shifting right
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/avm_hram_burst_tester_lfsr16.sv
// 16-bit Galois LFSR shared by the write-pattern and read-compare phases.
module lfsr16
    import avm_hram_tester_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/avm_hram_burst_tester.sv
// Avalon-MM burst master: writes an LFSR pattern over a region, reads it back and counts mismatches.
// Optional watchdog enabled by defining TESTER_TIMEOUT_EN.
module avm_hram_burst_tester
    import avm_hram_tester_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                BURST_LEN   = 16,
    parameter int                NUM_BURSTS  = 8,
    parameter int                TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic               timeout,
    output logic [ADDR_W-1:0]  avalon_master_address,
    output logic               avalon_master_read,
    output logic               avalon_master_write,
    output logic [DATA_W-1:0]  avalon_master_writedata,
    output logic [BURST_W-1:0] avalon_master_burstcount,
    input  logic               avalon_master_waitrequest,
    input  logic [DATA_W-1:0]  avalon_master_readdata,
    input  logic               avalon_master_readdatavalid
);

    localparam logic [BURST_W-1:0] BURST_CNT  = BURST_W'(BURST_LEN);
    localparam logic [BURST_W-1:0] LAST_BEAT  = BURST_W'(BURST_LEN - 1);
    localparam logic [15:0]        LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0]  BURST_STEP = ADDR_W'(2 * BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > 1024 || NUM_BURSTS < 1 || NUM_BURSTS > 65536 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536 || BASE_ADDR[0]) begin : g_param_check
        $error("avm_hram_burst_tester: illegal parameter value");
    end

    tester_state_t      state, state_next;
    logic [DATA_W-1:0]  seed_reg, seed_eff, lfsr_seed, lfsr_value;
    logic [BURST_W-1:0] beat_cnt;
    logic [15:0]        burst_cnt, err_after;
    logic               start_ok, wr_accept, rd_accept, rd_beat;
    logic               last_beat, last_burst, lfsr_load, mismatch, wd_fire;

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign wr_accept  = (state == ST_WR_BURST) && !avalon_master_waitrequest;
    assign rd_accept  = (state == ST_RD_CMD) && !avalon_master_waitrequest;
    assign rd_beat    = (state == ST_RD_DATA) && avalon_master_readdatavalid;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_burst = (burst_cnt == LAST_BURST);
    assign seed_eff   = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    assign mismatch   = rd_beat && (avalon_master_readdata != lfsr_value);
    assign err_after  = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

    // The final write beat reloads the pattern so the read phase replays it from the seed
    assign lfsr_load  = start_ok || (wr_accept && last_beat && last_burst);
    assign lfsr_seed  = start_ok ? seed_eff : seed_reg;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .seed    (lfsr_seed),
        .advance (wr_accept || rd_beat),
        .value   (lfsr_value)
    );

    assign busy                     = (state == ST_WR_BURST) || (state == ST_RD_CMD) || (state == ST_RD_DATA);
    assign done                     = (state == ST_DONE);
    assign avalon_master_write      = (state == ST_WR_BURST);
    assign avalon_master_read       = (state == ST_RD_CMD);
    assign avalon_master_burstcount = (avalon_master_write || avalon_master_read) ? BURST_CNT : '0;
    assign avalon_master_writedata  = avalon_master_write ? lfsr_value : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_WR_BURST;
            ST_WR_BURST:      if (wr_accept && last_beat && last_burst) state_next = ST_RD_CMD;
            ST_RD_CMD:        if (rd_accept) state_next = ST_RD_DATA;
            ST_RD_DATA:       if (rd_beat && last_beat) state_next = last_burst ? ST_DONE : ST_RD_CMD;
            default:          state_next = ST_IDLE;
        endcase
        if (wd_fire) state_next = ST_DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= ST_IDLE;
            seed_reg              <= '0;
            avalon_master_address <= BASE_ADDR;
            beat_cnt              <= '0;
            burst_cnt             <= '0;
            err_count             <= '0;
            pass                  <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                seed_reg              <= seed_eff;
                avalon_master_address <= BASE_ADDR;
                beat_cnt              <= '0;
                burst_cnt             <= '0;
                err_count             <= '0;
                pass                  <= 1'b0;
            end else if (wr_accept || rd_beat) begin
                err_count <= err_after;
                beat_cnt  <= last_beat ? '0 : beat_cnt + BURST_W'(1);
                if (last_beat) begin
                    if (wr_accept && last_burst) begin
                        avalon_master_address <= BASE_ADDR;
                        burst_cnt             <= '0;
                    end else begin
                        avalon_master_address <= avalon_master_address + BURST_STEP;
                        burst_cnt             <= burst_cnt + 16'd1;
                    end
                    if (rd_beat && last_burst) pass <= (err_after == '0);
                end
            end
        end
    end

`ifdef TESTER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wd_cnt;
    logic        progress;

    assign progress = wr_accept || rd_accept || rd_beat;
    assign wd_fire  = busy && !progress && (wd_cnt == WD_LAST);

    // Counts consecutive busy cycles without bus progress; pass stays 0 once it fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (start_ok) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (wd_fire) begin
            wd_cnt  <= '0;
            timeout <= 1'b1;
        end else if (progress || !busy) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_avm_hram_burst_tester.sv
// Scoreboard bench for avm_hram_burst_tester with a memory-backed Avalon slave model.
`timescale 1ns/1ps
module tb_avm_hram_burst_tester;

    localparam int BURST_LEN   = 16;
    localparam int NUM_BURSTS  = 8;
    localparam int TOTAL       = BURST_LEN * NUM_BURSTS;
    localparam int TIMEOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] address;
    logic        read, write;
    logic [15:0] writedata;
    logic [10:0] burstcount;
    logic        waitrequest = 1'b0;
    logic [15:0] readdata = 16'h0;
    logic        readdatavalid = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave model state
    logic [15:0] mem [0:255];
    int          stall_cycles = 0, stall_cnt = 0, wr_in_burst = 0;
    int          wr_beats = 0, rd_cmds = 0, rd_sent = 0;
    int          rd_pending = 0, rd_idx = 0, rd_delay = 0;
    int          flip_a = -1, flip_b = -1;
    int          last_rdv_cyc = 0, rd_cmd_cyc = 0;
    bit          no_rdv = 0, spurious = 0, prev_stall_wr = 0;
    logic [31:0] prev_addr;
    logic [15:0] prev_wdata, first_wdata;

    logic [58:0] exp_wr_q[$];
    logic [42:0] exp_rd_q[$];

    avm_hram_burst_tester #(
        .BASE_ADDR   (32'h0000_0000),
        .BURST_LEN   (BURST_LEN),
        .NUM_BURSTS  (NUM_BURSTS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .start                       (start),
        .seed                        (seed),
        .busy                        (busy),
        .done                        (done),
        .pass                        (pass),
        .err_count                   (err_count),
        .timeout                     (timeout),
        .avalon_master_address       (address),
        .avalon_master_read          (read),
        .avalon_master_write         (write),
        .avalon_master_writedata     (writedata),
        .avalon_master_burstcount    (burstcount),
        .avalon_master_waitrequest   (waitrequest),
        .avalon_master_readdata      (readdata),
        .avalon_master_readdatavalid (readdatavalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model_lfsr(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Slave acts on the falling edge: decides waitrequest/readdatavalid for the next rising edge
    task automatic slave_run();
        logic [58:0] exp_w;
        logic [42:0] exp_r;
        int unsigned idx;
        forever begin
            @(negedge clk);
            if (prev_stall_wr) begin
                checks++;
                if (!write || address !== prev_addr || writedata !== prev_wdata) begin
                    errors++;
                    $display("[TB] FAIL stall_stable got w=%b addr=%h data=%h required w=1 addr=%h data=%h",
                             write, address, writedata, prev_addr, prev_wdata);
                end
            end
            prev_stall_wr = 0;
            waitrequest = 1'b0;
            if (write || read) begin
                if (stall_cnt < stall_cycles) begin
                    waitrequest = 1'b1;
                    stall_cnt++;
                    prev_stall_wr = write;
                    prev_addr = address;
                    prev_wdata = writedata;
                end else if (write) begin
                    stall_cnt = 0;
                    wr_beats++;
                    if (wr_beats == 1) first_wdata = writedata;
                    idx = (32'(address >> 1) + 32'(wr_in_burst)) % 256;
                    mem[idx] = writedata;
                    wr_in_burst = (wr_in_burst + 1) % BURST_LEN;
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL wr_beat got extra beat addr=%h data=%h required no beat", address, writedata);
                    end else begin
                        exp_w = exp_wr_q.pop_front();
                        if ({address, burstcount, writedata} !== exp_w) begin
                            errors++;
                            $display("[TB] FAIL wr_beat %0d got addr=%h bc=%0d data=%h required addr=%h bc=%0d data=%h",
                                     wr_beats, address, burstcount, writedata, exp_w[58:27], exp_w[26:16], exp_w[15:0]);
                        end
                    end
                end else begin
                    stall_cnt = 0;
                    rd_cmds++;
                    rd_cmd_cyc = cyc;
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL rd_cmd got extra command addr=%h required none", address);
                    end else begin
                        exp_r = exp_rd_q.pop_front();
                        if ({address, burstcount} !== exp_r || rd_pending != 0) begin
                            errors++;
                            $display("[TB] FAIL rd_cmd %0d got addr=%h bc=%0d pending=%0d required addr=%h bc=%0d pending=0",
                                     rd_cmds, address, burstcount, rd_pending, exp_r[42:11], exp_r[10:0]);
                        end
                    end
                    rd_pending = BURST_LEN;
                    rd_idx = int'(address >> 1);
                    rd_delay = 2;
                end
            end
            readdatavalid = 1'b0;
            readdata = 16'($urandom_range(0, 65535));
            if (rd_delay > 0) begin
                rd_delay--;
            end else if (rd_pending > 0 && !no_rdv) begin
                readdatavalid = 1'b1;
                readdata = mem[rd_idx % 256];
                if (rd_sent == flip_a || rd_sent == flip_b) readdata = readdata ^ 16'h0001;
                rd_idx++;
                rd_pending--;
                rd_sent++;
                last_rdv_cyc = cyc;
            end else if (spurious && write) begin
                readdatavalid = 1'b1;
            end
        end
    endtask

    initial slave_run();

    task automatic slave_clear();
        stall_cnt = 0; wr_in_burst = 0; rd_pending = 0; rd_delay = 0;
        wr_beats = 0; rd_cmds = 0; rd_sent = 0; prev_stall_wr = 0;
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic start_run(input logic [15:0] s);
        logic [15:0] v;
        logic [31:0] a;
        slave_clear();
        v = (s == 16'h0) ? 16'hACE1 : s;
        for (int b = 0; b < NUM_BURSTS; b++) begin
            a = 32'(b * 2 * BURST_LEN);
            exp_rd_q.push_back({a, 11'(BURST_LEN)});
            for (int i = 0; i < BURST_LEN; i++) begin
                exp_wr_q.push_back({a, 11'(BURST_LEN), v});
                v = model_lfsr(v);
            end
        end
        @(negedge clk);
        start = 1'b1;
        seed = s;
        @(negedge clk);
        start = 1'b0;
        seed = 16'h5A5A;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_done_wait got done=0 after %0d cycles required done=1", name, budget);
        end
    endtask

    task automatic check_result(input string name, input bit exp_pass, input logic [15:0] exp_err);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || err_count !== exp_err || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_result got done=%b busy=%b pass=%b err=%0d to=%b required done=1 busy=0 pass=%b err=%0d to=0",
                     name, done, busy, pass, err_count, timeout, exp_pass, exp_err);
        end
        checks++;
        if (wr_beats != TOTAL || rd_sent != TOTAL || rd_cmds != NUM_BURSTS || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_counts got wr=%0d rd=%0d cmds=%0d left=%0d/%0d required wr=%0d rd=%0d cmds=%0d left=0/0",
                     name, wr_beats, rd_sent, rd_cmds, exp_wr_q.size(), exp_rd_q.size(), TOTAL, TOTAL, NUM_BURSTS);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, pass, timeout, read, write} !== 6'b0 || err_count !== 16'h0 ||
            address !== 32'h0 || writedata !== 16'h0 || burstcount !== 11'h0) begin
            errors++;
            $display("[TB] FAIL %s got busy=%b done=%b pass=%b to=%b rd=%b wr=%b err=%h addr=%h wd=%h bc=%0d required all 0",
                     name, busy, done, pass, timeout, read, write, err_count, address, writedata, burstcount);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_state");
    endtask

    task automatic test_ideal();
        int rdv_at;
        stall_cycles = 0;
        start_run(16'h0001);
        checks++;
        if (busy !== 1'b1 || write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_rise got busy=%b write=%b required busy=1 write=1", busy, write);
        end
        checks++;
        if (first_wdata !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL first_wdata got %h required 0001", first_wdata);
        end
        wait_done("ideal", 2000);
        rdv_at = last_rdv_cyc;
        checks++;
        if (cyc != rdv_at + 1) begin
            errors++;
            $display("[TB] FAIL done_latency got %0d cycles required 1", cyc - rdv_at);
        end
        check_result("ideal", 1'b1, 16'd0);
    endtask

    task automatic test_stall();
        stall_cycles = 3;
        spurious = 1;
        start_run(16'h0001);
        repeat (40) @(negedge clk);
        start = 1'b1;
        seed = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        wait_done("stall", 5000);
        check_result("stall", 1'b1, 16'd0);
        stall_cycles = 0;
        spurious = 0;
    endtask

    task automatic test_errors();
        flip_a = 5;
        flip_b = 70;
        start_run(16'hBEEF);
        wait_done("errors", 2000);
        check_result("errors", 1'b0, 16'd2);
        flip_a = -1;
        flip_b = -1;
    endtask

    task automatic test_seed_zero();
        start_run(16'h0000);
        checks++;
        if (first_wdata !== 16'hACE1) begin
            errors++;
            $display("[TB] FAIL seed_zero_first got %h required ACE1", first_wdata);
        end
        wait_done("seed_zero", 2000);
        check_result("seed_zero", 1'b1, 16'd0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start_run(16'h7777);
        while (wr_beats < 2 * BURST_LEN + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        repeat (2) @(negedge clk);
        slave_clear();
        reset_n = 1'b1;
        start_run(16'h3C3C);
        wait_done("after_reset", 2000);
        check_result("after_reset", 1'b1, 16'd0);
    endtask

`ifdef TESTER_TIMEOUT_EN
    task automatic test_timeout();
        no_rdv = 1;
        start_run(16'h0101);
        wait_done("timeout", 2000);
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_flags got to=%b pass=%b rd=%b wr=%b required to=1 pass=0 rd=0 wr=0",
                     timeout, pass, read, write);
        end
        checks++;
        if (cyc - rd_cmd_cyc != TIMEOUT_CYC + 1) begin
            errors++;
            $display("[TB] FAIL timeout_latency got %0d required %0d", cyc - rd_cmd_cyc, TIMEOUT_CYC + 1);
        end
        no_rdv = 0;
        rd_pending = 0;
        start_run(16'h0202);
        wait_done("post_timeout", 2000);
        check_result("post_timeout", 1'b1, 16'd0);
    endtask
`else
    task automatic test_timeout();
        no_rdv = 1;
        start_run(16'h0101);
        repeat (TOTAL + 300) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hung_slave got busy=%b done=%b to=%b required busy=1 done=0 to=0", busy, done, timeout);
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        no_rdv = 0;
        slave_clear();
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        $display("[TB] starting avm_hram_burst_tester bench");
        test_reset();
        test_ideal();
        test_stall();
        test_errors();
        test_seed_zero();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
